// File: rtl/sm4_check_pkg.sv
// Shared types and default widths for the SM4 loopback result checker.
package sm4_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/sm4_ref_fifo.sv
// First-word-fall-through reference FIFO; the head is readable combinationally.
module sm4_ref_fifo
  import sm4_check_pkg::*;
#(
  parameter int unsigned P_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned P_DEPTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [P_WIDTH-1:0]         i_din,
  output logic [P_WIDTH-1:0]         o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(P_DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               do_wr, do_rd;

  assign o_full  = (level_q == LVL_FULL);
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_dout  = mem[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_wr = i_push && (!o_full || i_pop);
  assign do_rd = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd)      level_d = level_q + LVL_ONE;
    else if (!do_wr && do_rd) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/sm4_loopback_checker.sv
// Compares SM4 decryptor output against buffered plaintext; counts results and
// latches ordering/liveness faults.
//   state   | meaning
//   S_IDLE  | nothing outstanding
//   S_WAIT  | blocks outstanding, timeout counter running
//   S_FAULT | overflow/underflow/timeout seen, everything frozen until clear
module sm4_loopback_checker
  import sm4_check_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned P_FIFO_DEPTH = 64,
  parameter int unsigned P_CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned P_TIMEOUT    = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_clear,
  input  logic [P_DATA_WIDTH-1:0]         i_plain_data,
  input  logic                            i_plain_valid,
  input  logic [P_DATA_WIDTH-1:0]         i_result_data,
  input  logic                            i_result_valid,
  output logic [P_CNT_WIDTH-1:0]          o_pass_cnt,
  output logic [P_CNT_WIDTH-1:0]          o_fail_cnt,
  output logic [P_DATA_WIDTH-1:0]         o_fail_expected,
  output logic [P_DATA_WIDTH-1:0]         o_fail_actual,
  output logic                            o_overflow,
  output logic                            o_underflow,
  output logic                            o_timeout,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_level,
  output logic [3:0]                      o_led
);

  localparam int unsigned LW = $clog2(P_FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(P_TIMEOUT + 1);
  localparam logic [TW-1:0]          TMO_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [TW-1:0]          TMO_ONE  = TW'(1);
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = P_CNT_WIDTH'(1);
  localparam logic [LW-1:0]          LVL_ONE  = LW'(1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [P_CNT_WIDTH-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic [P_DATA_WIDTH-1:0] exp_q, exp_d, act_q, act_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, to_q, to_d;
  logic [3:0]              led_q, led_d;

  logic                    srst, push, pop, full, empty;
  logic                    active, ovf_ev, unf_ev, to_ev;
  logic [P_DATA_WIDTH-1:0] head;
  logic [LW-1:0]           level;

  assign srst = i_rst || i_clear;

  sm4_ref_fifo #(
    .P_WIDTH (P_DATA_WIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (srst),
    .i_push  (push),
    .i_pop   (pop),
    .i_din   (i_plain_data),
    .o_dout  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (level)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    exp_d   = exp_q;
    act_d   = act_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    to_d    = to_q;
    push    = 1'b0;
    pop     = 1'b0;

    active = (state_q != S_FAULT);
    unf_ev = active && i_result_valid && empty;
    ovf_ev = active && i_plain_valid && full && !i_result_valid;
    to_ev  = (state_q == S_WAIT) && !i_result_valid && (tmo_q == TMO_LAST);

    // Any fault in a cycle suppresses that cycle's push and pop as well.
    if (unf_ev || ovf_ev || to_ev) begin
      state_d = S_FAULT;
      if (unf_ev) unf_d = 1'b1;
      if (ovf_ev) ovf_d = 1'b1;
      if (to_ev)  to_d  = 1'b1;
    end else if (active) begin
      push = i_plain_valid;
      pop  = i_result_valid;
      if (pop) begin
        tmo_d = '0;
        if (head == i_result_data) begin
          if (pass_q != '1) pass_d = pass_q + CNT_ONE;
        end else begin
          if (fail_q != '1) fail_d = fail_q + CNT_ONE;
          if (fail_q == '0) begin
            exp_d = head;
            act_d = i_result_data;
          end
        end
      end else if (state_q == S_WAIT) begin
        tmo_d = tmo_q + TMO_ONE;
      end
      case (state_q)
        S_IDLE: begin
          if (push) begin
            state_d = S_WAIT;
            tmo_d   = '0;
          end
        end
        S_WAIT: begin
          if (pop && !push && level == LVL_ONE) state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end

    led_d = {to_d, ovf_d || unf_d, fail_d != '0, pass_d != '0};
  end

  always_ff @(posedge i_clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      exp_q   <= '0;
      act_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      to_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      exp_q   <= exp_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      to_q    <= to_d;
      led_q   <= led_d;
    end
  end

  assign o_pass_cnt      = pass_q;
  assign o_fail_cnt      = fail_q;
  assign o_fail_expected = exp_q;
  assign o_fail_actual   = act_q;
  assign o_overflow      = ovf_q;
  assign o_underflow     = unf_q;
  assign o_timeout       = to_q;
  assign o_level         = level;
  assign o_led           = led_q;

endmodule
